synaptic_accumulator_array: RTL and testbench

//  Parametrised multi-channel successor to the single-output accumulator.

---
 rtl/synaptic_accumulator_array.sv | 142 ++++++++++++++
 tb/tb_synaptic_accumulator_array.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/synaptic_accumulator_array.sv
// rtl/synaptic_accumulator_array.sv - per-step multi-channel synaptic weight accumulator
module synaptic_accumulator_array #(
  parameter int ADDR_W   = 10,
  parameter int N_POST   = 4,
  parameter int WEIGHT_W = 16,
  parameter int ACC_W    = 32,
  localparam int POST_W  = (N_POST > 1) ? $clog2(N_POST) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      time_step,
  input  logic                      load,
  input  logic [ADDR_W-1:0]         load_addr,
  input  logic [POST_W-1:0]         load_post,
  input  logic [WEIGHT_W-1:0]       load_data,
  input  logic                      spike_valid,
  input  logic [ADDR_W-1:0]         spike_addr,
  output logic                      spike_ready,
  output logic [N_POST*ACC_W-1:0]   acc_out,
  output logic [N_POST-1:0]         acc_sat,
  output logic                      acc_valid,
  output logic                      ts_overrun
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {RUN, DRAIN, COMMIT} state_t;

  state_t state, state_nxt;
  logic   drain_cnt;

  logic [N_POST*WEIGHT_W-1:0] weight_mem [2**ADDR_W];
  logic [N_POST*WEIGHT_W-1:0] s1_row;
  logic                       s1_valid;

  logic [ACC_W-1:0] sums    [N_POST];
  logic [ACC_W-1:0] sum_nxt [N_POST];
  logic [ACC_W:0]   wide    [N_POST];
  logic [ACC_W:0]   w_ext   [N_POST];
  logic [N_POST-1:0]        sat_flags;
  logic [N_POST-1:0]        clamp;
  logic [N_POST*ACC_W-1:0]  sums_flat;

  logic accept;
  assign accept = spike_valid & spike_ready;

  // Weight writes land in any state; memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (load) begin
      weight_mem[load_addr][load_post*WEIGHT_W +: WEIGHT_W] <= load_data;
    end
  end

  // Stage 1: synchronous row read; a same-cycle write to the row is not seen.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_row <= weight_mem[spike_addr];
    end
  end

  // Stage-1 valid bit; reset kills any spike still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
    end
  end

  // Saturating add of each sign-extended weight into its running sum.
  always_comb begin
    clamp = '0;
    sums_flat = '0;
    for (int k = 0; k < N_POST; k++) begin
      w_ext[k] = {{(ACC_W+1-WEIGHT_W){s1_row[k*WEIGHT_W+WEIGHT_W-1]}},
                  s1_row[k*WEIGHT_W +: WEIGHT_W]};
      wide[k] = {sums[k][ACC_W-1], sums[k]} + w_ext[k];
      sum_nxt[k] = wide[k][ACC_W-1:0];
      if (wide[k][ACC_W] != wide[k][ACC_W-1]) begin
        clamp[k] = 1'b1;
        sum_nxt[k] = wide[k][ACC_W] ? ACC_MIN : ACC_MAX;
      end
      sums_flat[k*ACC_W +: ACC_W] = sums[k];
    end
  end

  // Running sums and saturation flags; cleared when a step is committed.
  always_ff @(posedge clk) begin
    if (rst || state == COMMIT) begin
      for (int k = 0; k < N_POST; k++) sums[k] <= '0;
      sat_flags <= '0;
    end else if (s1_valid) begin
      for (int k = 0; k < N_POST; k++) sums[k] <= sum_nxt[k];
      sat_flags <= sat_flags | clamp;
    end
  end

  // Next-state logic: RUN -> DRAIN (two cycles) -> COMMIT -> RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (time_step) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = COMMIT;
      COMMIT:  state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Drain cycle counter, only meaningful while in DRAIN.
  always_ff @(posedge clk) begin
    if (rst || state != DRAIN) begin
      drain_cnt <= 1'b0;
    end else begin
      drain_cnt <= ~drain_cnt;
    end
  end

  // State register plus registered ready, publish and overrun outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      spike_ready <= 1'b1;
      acc_out     <= '0;
      acc_sat     <= '0;
      acc_valid   <= 1'b0;
      ts_overrun  <= 1'b0;
    end else begin
      state       <= state_nxt;
      spike_ready <= (state_nxt == RUN);
      acc_valid   <= (state == COMMIT);
      if (state == COMMIT) begin
        acc_out <= sums_flat;
        acc_sat <= sat_flags;
      end
      if (time_step && state != RUN) begin
        ts_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_synaptic_accumulator_array.sv
// tb/tb_synaptic_accumulator_array.sv - self-checking bench for synaptic_accumulator_array
module tb_synaptic_accumulator_array;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         time_step = 1'b0;
  logic         load = 1'b0;
  logic [9:0]   load_addr = '0;
  logic [1:0]   load_post = '0;
  logic [15:0]  load_data = '0;
  logic         spike_valid = 1'b0;
  logic [9:0]   spike_addr = '0;

  logic         spike_ready, acc_valid, ts_overrun;
  logic [127:0] acc_out;
  logic [3:0]   acc_sat;
  logic         b_spike_ready, b_acc_valid, b_ts_overrun;
  logic [63:0]  b_acc_out;
  logic [3:0]   b_acc_sat;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  synaptic_accumulator_array dut (
    .clk(clk), .rst(rst), .time_step(time_step), .load(load),
    .load_addr(load_addr), .load_post(load_post), .load_data(load_data),
    .spike_valid(spike_valid), .spike_addr(spike_addr), .spike_ready(spike_ready),
    .acc_out(acc_out), .acc_sat(acc_sat), .acc_valid(acc_valid), .ts_overrun(ts_overrun)
  );

  synaptic_accumulator_array #(.ACC_W(16), .WEIGHT_W(16)) dut16 (
    .clk(clk), .rst(rst), .time_step(time_step), .load(load),
    .load_addr(load_addr), .load_post(load_post), .load_data(load_data),
    .spike_valid(spike_valid), .spike_addr(spike_addr), .spike_ready(b_spike_ready),
    .acc_out(b_acc_out), .acc_sat(b_acc_sat), .acc_valid(b_acc_valid), .ts_overrun(b_ts_overrun)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
    logic [31:0] wa, wb, wc, wd;
    wa = a; wb = b; wc = c; wd = d;
    return {wd, wc, wb, wa};
  endfunction

  // Behavioural model: step-level bookkeeping of weights, sums and the close window.
  int      w_m [1024][4];
  longint  m_sum [4];
  bit [3:0] m_sat_run = '0;
  logic [127:0] m_out = '0;
  logic [3:0]   m_sat = '0;
  bit      m_valid = 1'b0;
  bit      m_ready = 1'b1;
  bit      m_ovr = 1'b0;
  int      busy = 0;
  longint  v;
  longint  acc_max = 64'sd2147483647;
  longint  acc_min = -64'sd2147483648;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) m_sum[k] = 0;
      m_sat_run = '0; m_out = '0; m_sat = '0;
      m_valid = 1'b0; m_ready = 1'b1; m_ovr = 1'b0; busy = 0;
    end else begin
      m_valid = 1'b0;
      if (busy == 0 && spike_valid) begin
        for (int k = 0; k < 4; k++) begin
          v = m_sum[k] + longint'(w_m[spike_addr][k]);
          if (v > acc_max) begin v = acc_max; m_sat_run[k] = 1'b1; end
          if (v < acc_min) begin v = acc_min; m_sat_run[k] = 1'b1; end
          m_sum[k] = v;
        end
      end
      if (busy == 1) begin
        for (int k = 0; k < 4; k++) begin
          m_out[k*32 +: 32] = m_sum[k][31:0];
          m_sum[k] = 0;
        end
        m_sat = m_sat_run;
        m_sat_run = '0;
        m_valid = 1'b1;
      end
      if (busy != 0) begin
        if (time_step) m_ovr = 1'b1;
        busy--;
      end else if (time_step) begin
        busy = 3;
      end
      m_ready = (busy == 0);
    end
    if (load) w_m[load_addr][load_post] = int'($signed(load_data));
  end

  // Per-cycle comparison of the main instance against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("spike_ready", {127'd0, spike_ready}, {127'd0, m_ready});
      chk("acc_valid", {127'd0, acc_valid}, {127'd0, m_valid});
      chk("ts_overrun", {127'd0, ts_overrun}, {127'd0, m_ovr});
      chk("acc_out", acc_out, m_out);
      chk("acc_sat", {124'd0, acc_sat}, {124'd0, m_sat});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int addr, input int ch, input int data);
    logic [31:0] d;
    d = data;
    load = 1'b1; load_addr = addr[9:0]; load_post = ch[1:0]; load_data = d[15:0];
    tick();
    load = 1'b0;
  endtask

  task automatic load_row(input int addr, input int a, input int b, input int c, input int d);
    do_load(addr, 0, a); do_load(addr, 1, b); do_load(addr, 2, c); do_load(addr, 3, d);
  endtask

  task automatic do_spike(input int addr);
    spike_valid = 1'b1; spike_addr = addr[9:0];
    tick();
    spike_valid = 1'b0;
  endtask

  task automatic do_ts();
    time_step = 1'b1;
    tick();
    time_step = 1'b0;
  endtask

  // Waits for the publish pulse (bounded) and checks the ts-to-valid latency.
  task automatic wait_pub(input string name, input logic [127:0] exp_out, input logic [3:0] exp_sat);
    int cnt;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!acc_valid && cnt < 12);
    chk({name, "_latency"}, 128'(cnt), 128'd4);
    chk({name, "_out"}, acc_out, exp_out);
    chk({name, "_sat"}, {124'd0, acc_sat}, {124'd0, exp_sat});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    repeat (3) tick();
    rst = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_acc_out", acc_out, 128'd0);
    chk("rst_acc_sat", {124'd0, acc_sat}, 128'd0);
    chk("rst_acc_valid", {127'd0, acc_valid}, 128'd0);
    chk("rst_ts_overrun", {127'd0, ts_overrun}, 128'd0);
    chk("rst_spike_ready", {127'd0, spike_ready}, 128'd1);

    load_row(1, 1, 2, 3, 4);
    load_row(2, 10, 20, -5, 0);
    load_row(3, 32'h7FFF, 32'h8000, 0, 0);
    load_row(0, -1, -2, -3, -4);

    do_spike(1); do_spike(2); do_spike(1);
    do_ts();
    wait_pub("basic", pack4(12, 24, 1, 8), 4'b0000);

    tick();
    do_spike(3); do_spike(3);
    do_ts();
    wait_pub("sat32", pack4(65534, -65536, 0, 0), 4'b0000);
    chk("sat16_valid", {127'd0, b_acc_valid}, 128'd1);
    chk("sat16_out", {64'd0, b_acc_out}, {64'd0, 16'h0000, 16'h0000, 16'h8000, 16'h7FFF});
    chk("sat16_sat", {124'd0, b_acc_sat}, {124'd0, 4'b0011});

    tick();
    spike_valid = 1'b1; spike_addr = 10'd1; time_step = 1'b1;
    tick();
    time_step = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_ready_low", {127'd0, spike_ready}, 128'd0);
    end
    @(negedge clk);
    chk("hold_first_valid", {127'd0, acc_valid}, 128'd1);
    chk("hold_first_out", acc_out, pack4(1, 2, 3, 4));
    chk("hold_ready_back", {127'd0, spike_ready}, 128'd1);
    tick();
    spike_valid = 1'b0;
    do_ts();
    wait_pub("hold_second", pack4(1, 2, 3, 4), 4'b0000);

    tick();
    load = 1'b1; load_addr = 10'd1; load_post = 2'd0; load_data = 16'd100;
    spike_valid = 1'b1; spike_addr = 10'd1;
    tick();
    load = 1'b0; spike_valid = 1'b0;
    do_spike(1);
    do_ts();
    wait_pub("old_weight", pack4(101, 4, 6, 8), 4'b0000);

    tick();
    do_spike(0);
    do_ts();
    wait_pub("addr0", pack4(-1, -2, -3, -4), 4'b0000);

    tick();
    do_spike(1); do_spike(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_acc_out", acc_out, 128'd0);
    tick();
    do_spike(2);
    do_ts();
    wait_pub("after_rst", pack4(10, 20, -5, 0), 4'b0000);

    tick();
    time_step = 1'b1;
    tick();
    time_step = 1'b0;
    tick();
    time_step = 1'b1;
    tick();
    time_step = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (acc_valid) begin
        pulses++;
        chk("zero_step_out", acc_out, 128'd0);
      end
    end
    chk("overrun_pulses", 128'(pulses), 128'd1);
    chk("overrun_sticky", {127'd0, ts_overrun}, 128'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("overrun_cleared", {127'd0, ts_overrun}, 128'd0);
    tick();
    do_spike(2);
    do_ts();
    wait_pub("weights_kept", pack4(10, 20, -5, 0), 4'b0000);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
